// File: rtl/clk_period_mon_ctrl_if.sv
// Host-side bus of the clock-period monitor controller.
// CLKMON_MINMAX_EN adds the o_min_period / o_max_period outputs.
interface clk_period_mon_ctrl_if #(
    parameter int CNT_W  = 16,
    parameter int SAMP_W = 8
);
    // Handshake: i_start is a one-cycle pulse honoured only while idle; o_busy
    // rises the cycle after an accepted start and drops when o_done pulses for
    // one cycle; o_pass is valid with o_done and held until the next start;
    // i_abort cancels a run without a done pulse; o_period_vld pulses once per
    // update of o_last_period.
    logic              i_start;
    logic              i_abort;
    logic [CNT_W-1:0]  i_exp_period;
    logic [CNT_W-1:0]  i_tolerance;
    logic [SAMP_W-1:0] i_num_samples;
    logic              i_mon_in;
    logic              o_busy;
    logic              o_done;
    logic              o_pass;
    logic [SAMP_W-1:0] o_fail_cnt;
    logic [CNT_W-1:0]  o_last_period;
    logic              o_period_vld;
    logic              o_timeout;
    logic [2:0]        o_dbg_state;
`ifdef CLKMON_MINMAX_EN
    logic [CNT_W-1:0]  o_min_period;
    logic [CNT_W-1:0]  o_max_period;
`endif

    modport master (
        output i_start, i_abort, i_exp_period, i_tolerance, i_num_samples, i_mon_in,
        input  o_busy, o_done, o_pass, o_fail_cnt, o_last_period, o_period_vld,
               o_timeout, o_dbg_state
`ifdef CLKMON_MINMAX_EN
        , input o_min_period, o_max_period
`endif
    );

    modport slave (
        input  i_start, i_abort, i_exp_period, i_tolerance, i_num_samples, i_mon_in,
        output o_busy, o_done, o_pass, o_fail_cnt, o_last_period, o_period_vld,
               o_timeout, o_dbg_state
`ifdef CLKMON_MINMAX_EN
        , output o_min_period, o_max_period
`endif
    );
endinterface

// File: rtl/clk_period_mon_ctrl.sv
// Clock-period checker: measures periods of an asynchronous toggle in clk cycles
// and grades them against exp_period +/- tolerance. CLKMON_MINMAX_EN adds min/max.
module clk_period_mon_ctrl #(
    parameter int CNT_W       = 16,
    parameter int SAMP_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clk_period_mon_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_MEASURE = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [SAMP_W-1:0] SAMP_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_busy;
    logic               w_done;

    logic [SYNC_STAGES-1:0] r_sync;
    logic               r_sync_d;
    logic               w_rise;

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_exp;
    logic [CNT_W-1:0]   r_tol;
    logic [CNT_W-1:0]   r_last;
    logic [SAMP_W-1:0]  r_num;
    logic [SAMP_W-1:0]  r_samp;
    logic [SAMP_W-1:0]  r_fail;
    logic               r_pass;
    logic               r_timeout;
    logic               r_period_vld;
`ifdef CLKMON_MINMAX_EN
    logic [CNT_W-1:0]   r_min;
    logic [CNT_W-1:0]   r_max;
`endif

    logic               w_start_ok;
    logic               w_cnt_sat;
    logic [SAMP_W-1:0]  w_samp_inc;
    logic [CNT_W:0]     w_diff;
    logic               w_out_tol;
    logic [SAMP_W-1:0]  w_fail_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.i_mon_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_start_ok = (r_state == S_IDLE) && bus.i_start && !bus.i_abort;
    assign w_cnt_sat  = (r_cnt == CNT_MAX);
    assign w_samp_inc = r_samp + 1'b1;

    // Difference kept one bit wider so the tolerance compare never wraps.
    assign w_diff     = (r_last >= r_exp) ? {1'b0, r_last - r_exp} : {1'b0, r_exp - r_last};
    assign w_out_tol  = (w_diff > {1'b0, r_tol});
    assign w_fail_nxt = (w_out_tol && (r_fail != SAMP_MAX)) ? r_fail + 1'b1 : r_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = (bus.i_num_samples == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                w_busy = 1'b1;
                if (w_cnt_sat) begin
                    w_state_nxt = S_DONE;
                end else if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                w_busy = 1'b1;
                if (w_cnt_sat) begin
                    w_state_nxt = S_DONE;
                end else if (w_rise) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_busy      = 1'b1;
                w_state_nxt = (w_samp_inc == r_num) ? S_DONE : S_MEASURE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.i_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Saturation takes priority over an edge, so a captured period is never cnt+1 overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_exp        <= '0;
            r_tol        <= '0;
            r_last       <= '0;
            r_num        <= '0;
            r_samp       <= '0;
            r_fail       <= '0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_period_vld <= 1'b0;
`ifdef CLKMON_MINMAX_EN
            r_min        <= '0;
            r_max        <= '0;
`endif
        end else begin
            r_period_vld <= 1'b0;
            if (!bus.i_abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            r_exp     <= bus.i_exp_period;
                            r_tol     <= bus.i_tolerance;
                            r_num     <= bus.i_num_samples;
                            r_samp    <= '0;
                            r_cnt     <= '0;
                            r_fail    <= '0;
                            r_timeout <= 1'b0;
                            r_pass    <= (bus.i_num_samples == '0);
`ifdef CLKMON_MINMAX_EN
                            r_min     <= '0;
                            r_max     <= '0;
`endif
                        end
                    end
                    S_ARM: begin
                        if (w_cnt_sat) begin
                            r_timeout <= 1'b1;
                        end else if (w_rise) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (w_cnt_sat) begin
                            r_timeout <= 1'b1;
                        end else if (w_rise) begin
                            r_last       <= r_cnt + 1'b1;
                            r_cnt        <= '0;
                            r_period_vld <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_fail <= w_fail_nxt;
                        r_samp <= w_samp_inc;
                        if (w_samp_inc == r_num) begin
                            r_pass <= (w_fail_nxt == '0);
                        end
`ifdef CLKMON_MINMAX_EN
                        if (r_samp == '0) begin
                            r_min <= r_last;
                            r_max <= r_last;
                        end else begin
                            if (r_last < r_min) r_min <= r_last;
                            if (r_last > r_max) r_max <= r_last;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_busy        = w_busy;
    assign bus.o_done        = w_done;
    assign bus.o_pass        = r_pass;
    assign bus.o_fail_cnt    = r_fail;
    assign bus.o_last_period = r_last;
    assign bus.o_period_vld  = r_period_vld;
    assign bus.o_timeout     = r_timeout;
    assign bus.o_dbg_state   = r_state;
`ifdef CLKMON_MINMAX_EN
    assign bus.o_min_period  = r_min;
    assign bus.o_max_period  = r_max;
`endif
endmodule

// File: tb/tb_clk_period_mon_ctrl.sv
// Bench for clk_period_mon_ctrl: directed runs, expected periods and run results
// queued at stimulus time and compared by independent monitors.
module tb_clk_period_mon_ctrl;
    localparam int CNT_W  = 16;
    localparam int SAMP_W = 8;
    localparam int DW     = 2 + SAMP_W + CNT_W;
    localparam int DW8    = 2 + SAMP_W + 8;
    localparam int BUDGET = 3000;

    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    clk_period_mon_ctrl_if #(.CNT_W(CNT_W), .SAMP_W(SAMP_W)) bus ();
    clk_period_mon_ctrl_if #(.CNT_W(8), .SAMP_W(SAMP_W)) bus8 ();

    clk_period_mon_ctrl #(.CNT_W(CNT_W), .SAMP_W(SAMP_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    clk_period_mon_ctrl #(.CNT_W(8), .SAMP_W(SAMP_W), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]    exp_q[$];
    logic [DW8-1:0]   exp8_q[$];
    logic [CNT_W-1:0] per_q[$];
    int               half_q[$];
    logic             gen_busy;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Period monitor and result monitor for the 16-bit instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_period_vld) begin
                checks++;
                if (per_q.size() == 0) begin
                    errors++;
                    $display("FAIL period_vld_unexpected last_period=%0d expected no pulse", bus.o_last_period);
                end else begin
                    logic [CNT_W-1:0] e;
                    e = per_q.pop_front();
                    if (bus.o_last_period !== e) begin
                        errors++;
                        $display("FAIL last_period got=%0d expected=%0d", bus.o_last_period, e);
                    end
                end
            end
            if (bus.o_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected pass=%0d fail_cnt=%0d expected no done", bus.o_pass, bus.o_fail_cnt);
                end else begin
                    logic [DW-1:0] e;
                    logic [DW-1:0] g;
                    e = exp_q.pop_front();
                    g = {bus.o_pass, bus.o_timeout, bus.o_fail_cnt, bus.o_last_period};
                    if (g !== e) begin
                        errors++;
                        $display("FAIL run_result got pass=%0d timeout=%0d fail_cnt=%0d last=%0d expected pass=%0d timeout=%0d fail_cnt=%0d last=%0d",
                                 g[DW-1], g[DW-2], g[DW-3 -: SAMP_W], g[CNT_W-1:0],
                                 e[DW-1], e[DW-2], e[DW-3 -: SAMP_W], e[CNT_W-1:0]);
                    end
                end
            end
            if (bus8.o_done) begin
                checks++;
                if (exp8_q.size() == 0) begin
                    errors++;
                    $display("FAIL done8_unexpected timeout=%0d expected no done", bus8.o_timeout);
                end else begin
                    logic [DW8-1:0] e;
                    logic [DW8-1:0] g;
                    e = exp8_q.pop_front();
                    g = {bus8.o_pass, bus8.o_timeout, bus8.o_fail_cnt, bus8.o_last_period};
                    if (g !== e) begin
                        errors++;
                        $display("FAIL run8_result got=%h expected=%h", g, e);
                    end
                end
            end
        end
    end

    // Toggle generator: each queued entry is the number of clk cycles before the next mon_in toggle
    initial begin
        bus.i_mon_in = 1'b0;
        gen_busy     = 1'b0;
        forever begin
            @(negedge clk);
            if (half_q.size() != 0) begin
                int h;
                gen_busy = 1'b1;
                h = half_q.pop_front();
                repeat (h - 1) @(negedge clk);
                bus.i_mon_in = ~bus.i_mon_in;
                gen_busy = (half_q.size() != 0);
            end
        end
    end

    // Rises after a lead-in, then n periods of ha+hb cycles, ending low
    task automatic push_wave(input int n, input int ha, input int hb);
        half_q.push_back(4);
        for (int i = 0; i < n; i++) begin
            half_q.push_back(ha);
            half_q.push_back(hb);
        end
        half_q.push_back(ha);
    endtask

    task automatic push_per(input int n, input int p);
        for (int i = 0; i < n; i++) per_q.push_back(CNT_W'(p));
    endtask

    task automatic push_result(input logic p, input logic t, input int f, input int last);
        exp_q.push_back({p, t, SAMP_W'(f), CNT_W'(last)});
    endtask

    task automatic start_run(input int e, input int t, input int n);
        @(negedge clk);
        bus.i_exp_period  = CNT_W'(e);
        bus.i_tolerance   = CNT_W'(t);
        bus.i_num_samples = SAMP_W'(n);
        bus.i_start       = 1'b1;
        @(negedge clk);
        bus.i_start       = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || per_q.size() != 0 || half_q.size() != 0 || gen_busy || bus.o_busy)
               && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL %s drain_timeout exp_q=%0d per_q=%0d expected both empty", name, exp_q.size(), per_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_per_le(input int k, input string name);
        int n;
        n = 0;
        while (per_q.size() > k && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL %s period_wait_timeout per_q=%0d expected<=%0d", name, per_q.size(), k);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n              = 1'b0;
        bus.i_start        = 1'b0;
        bus.i_abort        = 1'b0;
        bus.i_exp_period   = '0;
        bus.i_tolerance    = '0;
        bus.i_num_samples  = '0;
        bus8.i_start       = 1'b0;
        bus8.i_abort       = 1'b0;
        bus8.i_exp_period  = '0;
        bus8.i_tolerance   = '0;
        bus8.i_num_samples = '0;
        bus8.i_mon_in      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_pass", bus.o_pass, 0);
        chk("rst_fail_cnt", bus.o_fail_cnt, 0);
        chk("rst_last_period", bus.o_last_period, 0);
        chk("rst_period_vld", bus.o_period_vld, 0);
        chk("rst_timeout", bus.o_timeout, 0);
        chk("rst_state", bus.o_dbg_state, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Toggle every 10 clk: four 20-cycle periods, exact match
        push_per(4, 20);
        push_result(1'b1, 1'b0, 0, 20);
        start_run(20, 0, 4);
        chk("t1_busy", bus.o_busy, 1);
        push_wave(4, 10, 10);
        wait_drain("t1");

        // Zero samples: straight to done with pass
        push_result(1'b1, 1'b0, 0, 20);
        start_run(20, 0, 0);
        chk("n0_busy", bus.o_busy, 0);
        wait_drain("n0");

        // Same stimulus against exp 10: every period fails
        push_per(4, 20);
        push_result(1'b0, 1'b0, 4, 20);
        start_run(10, 0, 4);
        push_wave(4, 10, 10);
        wait_drain("t2");

        // Periods of 21 against 20 +/- 1, then +/- 0
        push_per(6, 21);
        push_result(1'b1, 1'b0, 0, 21);
        start_run(20, 1, 6);
        push_wave(6, 10, 11);
        wait_drain("t3_tol1");
        push_per(6, 21);
        push_result(1'b0, 1'b0, 6, 21);
        start_run(20, 0, 6);
        push_wave(6, 10, 11);
        wait_drain("t3_tol0");

        // Abort after 2 of 8 samples (both out of tolerance vs 21)
        push_per(2, 20);
        start_run(21, 0, 8);
        push_wave(2, 10, 10);
        wait_per_le(0, "abort");
        repeat (2) @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_state", bus.o_dbg_state, 0);
        chk("abort_fail_hold", bus.o_fail_cnt, 2);
        chk("abort_pass_hold", bus.o_pass, 0);
        wait_drain("abort");

        // Abort while idle is a no-op; start together with abort is dropped
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("abort_idle_fail", bus.o_fail_cnt, 2);
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        bus.i_num_samples = 8'd4;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        chk("start_abort_busy", bus.o_busy, 0);
        chk("start_abort_fail", bus.o_fail_cnt, 2);
        chk("start_abort_done", bus.o_done, 0);

        // Clean rerun; a second start mid-run must be ignored
        push_per(4, 20);
        push_result(1'b1, 1'b0, 0, 20);
        start_run(20, 0, 4);
        push_wave(4, 10, 10);
        wait_per_le(3, "rerun");
        start_run(5, 0, 1);
        chk("busy_start_ignored", bus.o_busy, 1);
        wait_drain("rerun");

        // Periods 18, 20, 22
        per_q.push_back(16'd18);
        per_q.push_back(16'd20);
        per_q.push_back(16'd22);
        push_result(1'b1, 1'b0, 0, 22);
        start_run(20, 2, 3);
        half_q.push_back(4);
        half_q.push_back(9);
        half_q.push_back(9);
        half_q.push_back(10);
        half_q.push_back(10);
        half_q.push_back(11);
        half_q.push_back(11);
        half_q.push_back(5);
        wait_drain("minmax");
`ifdef CLKMON_MINMAX_EN
        chk("min_period", bus.o_min_period, 18);
        chk("max_period", bus.o_max_period, 22);
`endif
        per_q.push_back(16'd18);
        per_q.push_back(16'd20);
        per_q.push_back(16'd22);
        push_result(1'b0, 1'b0, 2, 22);
        start_run(20, 1, 3);
        half_q.push_back(4);
        half_q.push_back(9);
        half_q.push_back(9);
        half_q.push_back(10);
        half_q.push_back(10);
        half_q.push_back(11);
        half_q.push_back(11);
        half_q.push_back(5);
        wait_drain("spread_tol1");

        // Reset in the middle of an 8-sample run
        push_per(1, 20);
        start_run(20, 0, 8);
        push_wave(1, 10, 10);
        wait_per_le(0, "rst_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", bus.o_busy, 0);
        chk("rst_mid_done", bus.o_done, 0);
        chk("rst_mid_last_period", bus.o_last_period, 0);
        chk("rst_mid_fail_cnt", bus.o_fail_cnt, 0);
        chk("rst_mid_state", bus.o_dbg_state, 0);
        rst_n = 1'b1;
        wait_drain("rst_mid");

        // 8-bit counter, mon_in stuck low: timeout after the counter saturates
        exp8_q.push_back({1'b0, 1'b1, 8'd0, 8'd0});
        @(negedge clk);
        bus8.i_exp_period  = 8'd20;
        bus8.i_tolerance   = 8'd0;
        bus8.i_num_samples = 8'd2;
        bus8.i_start       = 1'b1;
        @(negedge clk);
        bus8.i_start       = 1'b0;
        cyc = 1;
        chk("to_busy", bus8.o_busy, 1);
        while (!bus8.o_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc < 250 || cyc > 260) begin
            errors++;
            $display("FAIL timeout_latency got=%0d cycles expected 250..260", cyc);
        end
        chk("to_timeout_flag", bus8.o_timeout, 1);
        @(negedge clk);
        chk("to_busy_after", bus8.o_busy, 0);
        chk("to_queue_empty", exp8_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
